// File: rtl/rom_rd_arbiter.sv
// Round-robin arbiter sharing one ROM read channel among N_REQ requesters.
// An in-order tag FIFO steers each returned word back to the requester that issued the address.
module rom_rd_arbiter #(
  parameter int N_REQ    = 2,
  parameter int W_ADDR   = 16,
  parameter int W_DATA   = 16,
  parameter int MAX_OUTS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_addr_valid,
  output logic [N_REQ-1:0]        req_addr_ready,
  input  logic [N_REQ*W_ADDR-1:0] req_addr_data,
  output logic [N_REQ-1:0]        req_data_valid,
  input  logic [N_REQ-1:0]        req_data_ready,
  output logic [W_DATA-1:0]       req_data_data,
  output logic                    mem_addr_valid,
  input  logic                    mem_addr_ready,
  output logic [W_ADDR-1:0]       mem_addr_data,
  input  logic                    mem_data_valid,
  output logic                    mem_data_ready,
  input  logic [W_DATA-1:0]       mem_data_data
);

  localparam int W_TAG = $clog2(N_REQ);
  localparam int W_PTR = $clog2(MAX_OUTS);
  localparam int W_CNT = W_PTR + 1;

  typedef logic [W_TAG-1:0] tag_t;

  tag_t             rr_ptr_q, rr_ptr_d;
  tag_t             gnt_q, gnt_d;
  logic             lock_q, lock_d;
  tag_t             tag_mem_q [MAX_OUTS];
  logic [W_PTR-1:0] wr_ptr_q, rd_ptr_q;
  logic [W_CNT-1:0] count_q, count_d;

  tag_t gnt;
  tag_t cand;
  tag_t head;
  logic found;
  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic pop;
  int   idx;

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    gnt   = rr_ptr_q;
    found = 1'b0;
    cand  = '0;
    idx   = 0;
    if (lock_q) begin
      gnt = gnt_q;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        cand = tag_t'(idx);
        if (!found && req_addr_valid[cand]) begin
          gnt   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign fifo_full  = (count_q == W_CNT'(MAX_OUTS));
  assign fifo_empty = (count_q == '0);
  assign head       = tag_mem_q[rd_ptr_q];

  // rst gates the handshake outputs directly so they fall the moment reset is asserted.
  assign mem_addr_valid = rst && req_addr_valid[gnt] && !fifo_full;
  assign mem_addr_data  = req_addr_data[int'(gnt)*W_ADDR +: W_ADDR];
  assign mem_data_ready = rst && !fifo_empty && req_data_ready[head];
  assign req_data_data  = mem_data_data;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_addr_ready[i] = rst && (tag_t'(i) == gnt) && mem_addr_ready && !fifo_full;
      req_data_valid[i] = rst && mem_data_valid && !fifo_empty && (head == tag_t'(i));
    end
  end

  assign accept = mem_addr_valid && mem_addr_ready;
  assign pop    = mem_data_valid && mem_data_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    lock_d   = lock_q;
    count_d  = count_q;
    if (accept) begin
      lock_d   = 1'b0;
      rr_ptr_d = (int'(gnt) == N_REQ - 1) ? '0 : gnt + tag_t'(1);
    end else if (mem_addr_valid) begin
      // Freeze the presented requester until the ROM wrapper takes it.
      lock_d = 1'b1;
      gnt_d  = gnt;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + W_CNT'(1);
      2'b01:   count_d = count_q - W_CNT'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      lock_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      lock_q   <= lock_d;
      count_q  <= count_d;
      if (accept) wr_ptr_q <= wr_ptr_q + W_PTR'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + W_PTR'(1);
    end
  end

  // NOTE: tag storage is not reset; entries are only read while count_q marks them valid.
  always_ff @(posedge clk) begin
    if (accept) tag_mem_q[wr_ptr_q] <= gnt;
  end

  a_no_data_when_empty: assert property (@(posedge clk) disable iff (!rst)
    !(mem_data_valid && fifo_empty));

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Randomized bench for rom_rd_arbiter: a queue-based model of the arbitration and return-order
// rules predicts every handshake output each cycle; a small ROM wrapper model serves the reads.
module tb_rom_rd_arbiter;

  localparam int N  = 3;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_addr_valid;
  logic [N-1:0]      req_addr_ready;
  logic [N-1:0][15:0] addr_arr;
  logic [N*16-1:0]   req_addr_data;
  logic [N-1:0]      req_data_valid;
  logic [N-1:0]      req_data_ready;
  logic [15:0]       req_data_data;
  logic              mem_addr_valid;
  logic              mem_addr_ready;
  logic [15:0]       mem_addr_data;
  logic              mem_data_valid;
  logic              mem_data_ready;
  logic [15:0]       mem_data_data;

  assign req_addr_data = addr_arr;

  always #5 clk = ~clk;

  rom_rd_arbiter #(.N_REQ(N), .W_ADDR(16), .W_DATA(16), .MAX_OUTS(MO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_addr_valid (req_addr_valid),
    .req_addr_ready (req_addr_ready),
    .req_addr_data  (req_addr_data),
    .req_data_valid (req_data_valid),
    .req_data_ready (req_data_ready),
    .req_data_data  (req_data_data),
    .mem_addr_valid (mem_addr_valid),
    .mem_addr_ready (mem_addr_ready),
    .mem_addr_data  (mem_addr_data),
    .mem_data_valid (mem_data_valid),
    .mem_data_ready (mem_data_ready),
    .mem_data_data  (mem_data_data)
  );

  typedef struct {
    int          tag;
    logic [15:0] addr;
  } out_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_done = 0;

  // Reference model: accepted reads in order, round-robin start point, and the stalled requester.
  out_t        outs[$];
  logic [15:0] mem_q[$];
  int          rr = 0;
  int          lock_idx = 0;
  bit          locked = 1'b0;

  bit          p_acc = 1'b0;
  bit          p_stall = 1'b0;
  bit          p_pop = 1'b0;
  int          p_g = 0;
  logic [15:0] p_maddr = '0;

  function automatic logic [15:0] rom_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_updates();
    if (p_pop) begin
      void'(outs.pop_front());
      void'(mem_q.pop_front());
      mem_data_valid = 1'b0;
      n_done++;
    end
    if (p_acc) begin
      outs.push_back('{p_g, addr_arr[p_g]});
      mem_q.push_back(p_maddr);
      rr = (p_g + 1) % N;
      locked = 1'b0;
      req_addr_valid[p_g] = 1'b0;
    end else if (p_stall) begin
      locked = 1'b1;
      lock_idx = p_g;
    end
    p_acc = 1'b0;
    p_stall = 1'b0;
    p_pop = 1'b0;
  endtask

  task automatic drive(input int pv, input int pmar, input int pdr, input int pmdv);
    for (int i = 0; i < N; i++) begin
      if (!req_addr_valid[i] && int'($urandom_range(99)) < pv) begin
        req_addr_valid[i] = 1'b1;
        addr_arr[i] = 16'($urandom);
      end
      req_data_ready[i] = int'($urandom_range(99)) < pdr;
    end
    mem_addr_ready = int'($urandom_range(99)) < pmar;
    if (!mem_data_valid && mem_q.size() > 0 && int'($urandom_range(99)) < pmdv) begin
      mem_data_valid = 1'b1;
      mem_data_data = rom_f(mem_q[0]);
    end
  endtask

  task automatic evaluate();
    int         g;
    int         head;
    bit         found;
    bit         full;
    bit         empty;
    bit         e_mav;
    bit         e_mdr;
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_rdv;
    full  = outs.size() >= MO;
    empty = outs.size() == 0;
    g = rr;
    found = 1'b0;
    if (locked) begin
      g = lock_idx;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!found && req_addr_valid[(rr + k) % N]) begin
          g = (rr + k) % N;
          found = 1'b1;
        end
      end
    end
    e_mav = req_addr_valid[g] && !full;
    e_rdy = '0;
    e_rdy[g] = mem_addr_ready && !full;
    head = empty ? 0 : outs[0].tag;
    e_rdv = '0;
    if (!empty) e_rdv[head] = mem_data_valid;
    e_mdr = !empty && req_data_ready[head];

    check("mem_addr_valid", 32'(mem_addr_valid), 32'(e_mav));
    if (e_mav) check("mem_addr_data", 32'(mem_addr_data), 32'(addr_arr[g]));
    check("req_addr_ready", 32'(req_addr_ready & req_addr_valid), 32'(e_rdy & req_addr_valid));
    check("req_data_valid", 32'(req_data_valid), 32'(e_rdv));
    check("mem_data_ready", 32'(mem_data_ready), 32'(e_mdr));
    if (!empty && mem_data_valid) check("req_data_data", 32'(req_data_data), 32'(rom_f(outs[0].addr)));

    p_g     = g;
    p_acc   = e_mav && mem_addr_ready;
    p_stall = e_mav && !mem_addr_ready;
    p_pop   = mem_data_valid && e_mdr;
    p_maddr = mem_addr_data;
  endtask

  task automatic run_phase(input int cycles, input int pv, input int pmar, input int pdr, input int pmdv);
    repeat (cycles) begin
      @(negedge clk);
      apply_updates();
      drive(pv, pmar, pdr, pmdv);
      #1;
      evaluate();
    end
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_mem_addr_valid"}, 32'(mem_addr_valid), 32'd0);
    check({tag, "_req_addr_ready"}, 32'(req_addr_ready), 32'd0);
    check({tag, "_req_data_valid"}, 32'(req_data_valid), 32'd0);
    check({tag, "_mem_data_ready"}, 32'(mem_data_ready), 32'd0);
  endtask

  initial begin
    int done_before;
    rst = 1'b0;
    req_addr_valid = '1;
    for (int i = 0; i < N; i++) addr_arr[i] = 16'h0010 * 16'(i + 1);
    req_data_ready = '1;
    mem_addr_ready = 1'b1;
    mem_data_valid = 1'b1;
    mem_data_data  = 16'hFFFF;
    #12;
    check_outputs_idle("in_reset");

    mem_data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("first_grant_addr", 32'(mem_addr_data), 32'h0010);
    evaluate();

    run_phase(200, 100, 100, 100, 100);
    run_phase(300,  60,  30,  80,  70);
    run_phase(150, 100, 100,   0, 100);
    run_phase(200,  80,  90,  40,  80);

    run_phase(60, 100, 100, 0, 100);
    @(negedge clk);
    apply_updates();
    req_data_ready = '1;
    mem_addr_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("midburst_outstanding", 32'(outs.size()), 32'(MO));
    check_outputs_idle("midburst_reset");
    outs.delete();
    mem_q.delete();
    rr = 0;
    locked = 1'b0;
    mem_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_idle("held_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    evaluate();
    done_before = n_done;
    run_phase(100, 100, 100, 100, 100);
    check("post_reset_reads_done", 32'(n_done > done_before), 32'd1);

    run_phase(400, 50, 50, 50, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
